// File: rtl/icache_refill.sv
// Instruction-cache refill engine: wins the shared byte-wide RAM port, streams one
// block in byte by byte and hands the assembled line to the cache fill port.
module icache_refill #(
  parameter int ADDR_WIDTH  = 17,
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
  input  logic                          clkIn,
  input  logic                          resetIn,
  input  logic                          missValid,
  input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] missAddr,
  input  logic                          flushIn,
  output logic                          busReq,
  input  logic                          busGrant,
  output logic [ADDR_WIDTH-1:0]         ramAddr,
  input  logic [7:0]                    ramDataIn,
  output logic                          busy,
  output logic                          memDataValid,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memAddr,
  output logic [BLOCK_SIZE*8-1:0]       memDataIn
);
  localparam int BLK_W = ADDR_WIDTH - BLOCK_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, READ, DONE} state_t;

  state_t                  state;
  logic [BLOCK_WIDTH:0]    cnt;
  logic [BLK_W-1:0]        blk;
  logic [BLOCK_SIZE*8-1:0] line;
  logic                    req;
  logic [BLOCK_WIDTH-1:0]  rd_lane;
  logic [BLOCK_WIDTH-1:0]  wr_lane;

  // Terminal cycle (cnt == BLOCK_SIZE) keeps the last address on the bus.
  assign rd_lane = cnt[BLOCK_WIDTH] ? '1 : cnt[BLOCK_WIDTH-1:0];
  // Data arrives one cycle after its address, so it lands one lane behind.
  assign wr_lane = cnt[BLOCK_WIDTH-1:0] - 1'b1;

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      state <= IDLE;
      cnt   <= '0;
      blk   <= '0;
      line  <= '0;
      req   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (missValid && !flushIn) begin
            blk   <= missAddr;
            line  <= '0;
            cnt   <= '0;
            req   <= 1'b1;
            state <= WAIT_GRANT;
          end
        end
        WAIT_GRANT: begin
          if (flushIn) begin
            req   <= 1'b0;
            state <= IDLE;
          end else if (busGrant) begin
            cnt   <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (flushIn) begin
            req   <= 1'b0;
            state <= IDLE;
          end else begin
            if (cnt != '0) line[wr_lane*8 +: 8] <= ramDataIn;
            if (cnt[BLOCK_WIDTH]) begin
              req   <= 1'b0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busReq       = req;
  assign busy         = (state != IDLE);
  assign ramAddr      = (state == READ) ? {blk, rd_lane} : '0;
  // A flush in the delivery cycle must still cancel the line.
  assign memDataValid = (state == DONE) && !flushIn;
  assign memAddr      = blk;
  assign memDataIn    = line;

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: directed vector table, hand-written corner sequences and
// randomized refills checked against a transaction-level model of the RAM and line.
module tb_icache_refill;
  localparam logic [127:0] L0 = 128'h3F3E3D3C3B3A39383736353433323130;

  logic         clkIn = 1'b0;
  logic         resetIn, missValid, flushIn, busGrant;
  logic [12:0]  missAddr;
  logic         busReq, busy, memDataValid;
  logic [16:0]  ramAddr;
  logic [7:0]   ramDataIn;
  logic [12:0]  memAddr;
  logic [127:0] memDataIn;

  int pass_cnt = 0;
  int total_cnt = 0;

  icache_refill dut (
    .clkIn(clkIn), .resetIn(resetIn), .missValid(missValid), .missAddr(missAddr),
    .flushIn(flushIn), .busReq(busReq), .busGrant(busGrant), .ramAddr(ramAddr),
    .ramDataIn(ramDataIn), .busy(busy), .memDataValid(memDataValid),
    .memAddr(memAddr), .memDataIn(memDataIn)
  );

  always #5 clkIn = ~clkIn;

  // RAM contents: seed 0 gives 0x30+addr[3:0], otherwise a seeded hash of the address.
  function automatic logic [7:0] ram_byte(input logic [16:0] a, input logic [7:0] s);
    if (s == 8'h00) return 8'h30 + {4'h0, a[3:0]};
    return 8'(a[7:0] * 8'd29 + a[16:8]) ^ s;
  endfunction

  function automatic logic [127:0] model_line(input logic [12:0] b, input logic [7:0] s);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = ram_byte({b, 4'(k)}, s);
    return l;
  endfunction

  // One-cycle-latency RAM: data for the previous cycle's address.
  logic [7:0]  ram_seed = 8'h00;
  logic [16:0] prev_addr = '0;
  always @(negedge clkIn) begin
    ramDataIn = ram_byte(prev_addr, ram_seed);
    prev_addr = ramAddr;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clkIn);
    #2;
  endtask

  typedef struct {
    logic [12:0]  addr;
    int           gdly;
    logic [7:0]   seed;
    int           abort;     // 0 none, 1 flush, 2 reset
    int           abort_at;  // cycle after grant edge (1 = first READ cycle, 18 = DONE)
    bit           noise;     // stray miss during READ
    logic [127:0] exp_line;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n, aerr, rerr, late;
    ram_seed  = v.seed;
    missAddr  = v.addr;
    missValid = 1'b1;
    step();
    missValid = 1'b0;
    chk("req_after_miss", 128'(busReq), 128'(1));
    chk("busy_after_miss", 128'(busy), 128'(1));
    for (int k = 0; k < v.gdly; k++) begin
      if (k == v.gdly - 1) begin
        chk("wait_req", 128'(busReq), 128'(1));
        chk("wait_ramaddr", 128'(ramAddr), 128'(0));
      end
      step();
    end
    busGrant = 1'b1;
    step();
    n = 1; aerr = 0; rerr = 0;
    while (n <= 40) begin
      if (v.abort != 0 && n == v.abort_at) begin
        if (v.abort == 1) flushIn = 1'b1; else resetIn = 1'b0;
        #1;
        if (v.abort == 1) chk("flush_no_pulse", 128'(memDataValid), 128'(0));
        step();
        flushIn = 1'b0; resetIn = 1'b1; busGrant = 1'b0; missValid = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_req", 128'(busReq), 128'(0));
        chk("abort_ramaddr", 128'(ramAddr), 128'(0));
        if (v.abort == 2) begin
          chk("reset_memaddr", 128'(memAddr), 128'(0));
          chk("reset_memdata", memDataIn, 128'(0));
        end
        late = 0;
        for (int k = 0; k < 22; k++) begin
          if (memDataValid || busy) late++;
          step();
        end
        chk("abort_stays_idle", 128'(late), 128'(0));
        return;
      end
      if (memDataValid) break;
      if (n <= 16 && ramAddr !== {v.addr, 4'(n - 1)}) aerr++;
      if (n == 17 && ramAddr !== {v.addr, 4'hF}) aerr++;
      if (!busReq) rerr++;
      if (v.noise && n >= 3 && n <= 5) begin
        missValid = 1'b1; missAddr = 13'h0777;
      end else missValid = 1'b0;
      busGrant = busReq;
      step();
      n++;
    end
    missValid = 1'b0;
    chk("latency", 128'(n), 128'(18));
    chk("read_addrs", 128'(aerr), 128'(0));
    chk("req_in_read", 128'(rerr), 128'(0));
    chk("pulse", 128'(memDataValid), 128'(1));
    chk("pulse_memaddr", 128'(memAddr), 128'(v.addr));
    chk("pulse_line", memDataIn, v.exp_line);
    chk("pulse_req_low", 128'(busReq), 128'(0));
    chk("pulse_ramaddr", 128'(ramAddr), 128'(0));
    busGrant = 1'b0;
    step();
    chk("after_pulse_valid", 128'(memDataValid), 128'(0));
    chk("after_pulse_busy", 128'(busy), 128'(0));
    chk("hold_memaddr", 128'(memAddr), 128'(v.addr));
    chk("hold_line", memDataIn, v.exp_line);
  endtask

  vec_t tbl[10];
  vec_t rv;
  int   cnt_act;

  initial begin
    tbl[0] = '{13'h0123,  2, 8'h00, 0,  0, 1'b0, L0};
    tbl[1] = '{13'h0123, 10, 8'h00, 0,  0, 1'b0, L0};
    tbl[2] = '{13'h0123,  1, 8'h00, 1,  8, 1'b0, L0};
    tbl[3] = '{13'h0456,  0, 8'hA7, 0,  0, 1'b0, model_line(13'h0456, 8'hA7)};
    tbl[4] = '{13'h0123,  2, 8'h00, 0,  0, 1'b1, L0};
    tbl[5] = '{13'h0123,  1, 8'h00, 2,  5, 1'b0, L0};
    tbl[6] = '{13'h0ABC,  0, 8'h00, 0,  0, 1'b0, L0};
    tbl[7] = '{13'h1FFF,  0, 8'h00, 0,  0, 1'b0, L0};
    tbl[8] = '{13'h0321,  1, 8'h3C, 1, 18, 1'b0, model_line(13'h0321, 8'h3C)};
    tbl[9] = '{13'h0000,  3, 8'h5A, 0,  0, 1'b0, model_line(13'h0000, 8'h5A)};

    resetIn = 1'b0; missValid = 1'b0; flushIn = 1'b0; busGrant = 1'b0; missAddr = '0;
    step(); step();
    chk("rst_busreq", 128'(busReq), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(memDataValid), 128'(0));
    chk("rst_ramaddr", 128'(ramAddr), 128'(0));
    chk("rst_memaddr", 128'(memAddr), 128'(0));
    chk("rst_memdata", memDataIn, 128'(0));

    resetIn = 1'b1;
    cnt_act = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (busy || busReq || memDataValid) cnt_act++;
    end
    chk("idle_hold", 128'(cnt_act), 128'(0));

    busGrant = 1'b1;
    step();
    chk("stray_grant_busy", 128'(busy), 128'(0));
    busGrant = 1'b0;

    missValid = 1'b1; flushIn = 1'b1; missAddr = 13'h0555;
    step();
    missValid = 1'b0; flushIn = 1'b0;
    chk("collision_req", 128'(busReq), 128'(0));
    chk("collision_busy", 128'(busy), 128'(0));

    // Vectors 6 -> 7 run back-to-back: the second miss lands in the IDLE cycle after DONE.
    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      rv.addr     = 13'($urandom_range(0, 8191));
      rv.gdly     = $urandom_range(0, 5);
      rv.seed     = 8'($urandom_range(1, 255));
      rv.abort    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rv.abort_at = $urandom_range(1, 18);
      rv.noise    = 1'($urandom_range(0, 1));
      rv.exp_line = model_line(rv.addr, rv.seed);
      run_vec(rv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Memory-side fill engine for the instruction cache.
- Accepts a miss request for one block address and arbitrates for the shared byte-wide RAM port.
- Reads the BLOCK_SIZE bytes of the block sequentially and assembles them into one line.
- Presents the line to the cache fill port (memDataValid / memAddr / memDataIn) as a single-cycle pulse.

Parameters:
- ADDR_WIDTH, 17, byte address width of RAM and instruction addresses.
- BLOCK_WIDTH, 4, log2 of block size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH, bytes per cache line (16).

Ports:
- clkIn  input  1  system clock.
- resetIn  input  1  reset; synchronous, active-low (0 = reset).
- missValid  input  1  cache reports a miss this cycle.
- missAddr  input  ADDR_WIDTH-BLOCK_WIDTH  block address of the miss (byte address bits ADDR_WIDTH-1:BLOCK_WIDTH).
- flushIn  input  1  pipeline flush; abandons any refill.
- busReq  output  1  request for the RAM port.
- busGrant  input  1  arbiter grant; held high by the arbiter while busReq is high.
- ramAddr  output  ADDR_WIDTH  RAM byte read address.
- ramDataIn  input  8  RAM read data; one-cycle read latency.
- busy  output  1  high in any state other than IDLE.
- memDataValid  output  1  one-cycle pulse: line is complete.
- memAddr  output  ADDR_WIDTH-BLOCK_WIDTH  block address of the delivered line.
- memDataIn  output  BLOCK_SIZE*8  assembled line; byte k in bits [8k+7:8k].

Behaviour:
- Reset (resetIn=0 at a clock edge):
  - State goes to IDLE; counters are cleared.
  - busReq, memDataValid, busy, ramAddr, memAddr and memDataIn are all 0.
  - Reset overrides everything, including mid-READ; no pulse is produced afterwards for the aborted line.
- States: IDLE, WAIT_GRANT, READ, DONE.
- IDLE:
  - On missValid=1 and flushIn=0, latch missAddr into blkReg and clear the line buffer.
  - Next state WAIT_GRANT; busReq=1 from the next cycle.
  - missValid with flushIn=1 in the same cycle: flush wins and the state stays IDLE.
- WAIT_GRANT:
  - busReq=1.
  - On busGrant=1, go to READ with issue counter i=0.
  - missValid and missAddr are ignored in every state except IDLE.
- READ (exactly BLOCK_SIZE+1 cycles):
  - Cycle j, for j=0..BLOCK_SIZE-1: ramAddr={blkReg, j[BLOCK_WIDTH-1:0]}.
  - Cycle j, for j=1..BLOCK_SIZE: ramDataIn is written into byte lane j-1.
  - In the final cycle (j=BLOCK_SIZE), ramAddr holds the last address and busReq stays 1.
  - After the final cycle, go to DONE.
- DONE (1 cycle):
  - memDataValid=1; memAddr=blkReg; memDataIn=assembled line.
  - busReq=0 in this cycle.
  - Next state IDLE.
  - memAddr and memDataIn hold their values until the next refill overwrites them; memDataValid returns to 0.
- Latency: if busGrant is first sampled high at edge g, memDataValid is high in the cycle after edge g+BLOCK_SIZE+1 (18 cycles after the grant cycle for the defaults).
- Flush:
  - flushIn=1 in WAIT_GRANT, READ or DONE goes to IDLE at the next edge.
  - busReq drops and no memDataValid pulse is produced.
  - In DONE, flush suppresses the pulse: memDataValid is combinational on state && !flushIn.
- Back-to-back: a miss in the IDLE cycle immediately after DONE is accepted normally, giving a minimum 1 idle cycle between refills.
- ramAddr is 0 in IDLE, WAIT_GRANT and DONE.
- Counters are BLOCK_WIDTH+1 bits wide so they do not wrap before terminal count. Lane index is the low BLOCK_WIDTH bits.
- busGrant outside WAIT_GRANT is ignored.

Test Plan:
- Basic refill: stimulus is missAddr=0x0123, grant 2 cycles after busReq rises, and RAM returning byte = 0x30+addr[3:0]. Required response: ramAddr steps 0x01230..0x0123F, then one memDataValid pulse with memAddr=0x0123 and memDataIn=128'h3F3E3D3C3B3A39383736353433323130. The pulse comes 18 cycles after grant, and busReq is low in the pulse cycle.
- Delayed grant: hold busGrant=0 for 10 cycles. Required response: busReq=1 throughout, ramAddr=0, no reads issued; the refill then completes identically to the basic case.
- Flush mid-READ: flushIn=1 when ramAddr=0x01237. Required response: the next cycle is IDLE, busReq=0, busy=0, no memDataValid. A new miss at 0x0456 then completes with the correct line.
- Miss/flush collision and ignored misses: missValid and flushIn high together in IDLE, so no busReq. missValid with missAddr=0x0777 during READ is ignored, so the delivered memAddr stays 0x0123.
- Reset mid-operation: resetIn=0 for 1 cycle during READ. Required response: all outputs 0, state IDLE, and no pulse afterwards. Also check that holding resetIn=1 while missValid=0 keeps the block idle.
- Back-to-back: a second miss (0x1FFF, top block) asserted in the cycle after DONE. Required response: accepted, ramAddr runs 0x1FFF0..0x1FFFF without overflow, and the pulse carries memAddr=0x1FFF.
